// File: rtl/lt24_pkg.sv
// Shared constants, FSM state type and window range check for the LT24 bus decoder.
package lt24_pkg;
    localparam int X_W        = 8;
    localparam int Y_W        = 9;
    localparam int LCD_WIDTH  = 240;
    localparam int LCD_HEIGHT = 320;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_IGNORE
    } lt24_state_e;

    // Checked on the full 16-bit values so oversized parameters are rejected, not truncated.
    function automatic logic range_ok(input logic [15:0] start_v,
                                      input logic [15:0] end_v,
                                      input logic [15:0] limit_v);
        return (start_v <= end_v) && (end_v < limit_v);
    endfunction
endpackage

// File: rtl/lt24_write_strobe.sv
// Registers the LT24 bus once and turns each CS-qualified Wr_n rising edge into a one-cycle
// writeEvent, presenting the RS/Data values that were on the bus while Wr_n was low.
module lt24_write_strobe (
    input  logic        clock,
    input  logic        reset,
    input  logic        LT24Wr_n,
    input  logic        LT24CS_n,
    input  logic        LT24RS,
    input  logic        LT24Reset_n,
    input  logic [15:0] LT24Data,
    output logic        writeEvent,
    output logic        isData,
    output logic [15:0] data,
    output logic        lcdReset
);
    logic        wr1_q, wr2_q, cs1_q, rs1_q, rstn1_q;
    logic [15:0] data1_q;
    logic        cap_cs_n_q, cap_rs_q;
    logic [15:0] cap_data_q;
    logic        event_q, lcd_reset_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr1_q       <= 1'b1;
            wr2_q       <= 1'b1;
            cs1_q       <= 1'b1;
            rs1_q       <= 1'b0;
            rstn1_q     <= 1'b1;
            data1_q     <= '0;
            cap_cs_n_q  <= 1'b1;
            cap_rs_q    <= 1'b0;
            cap_data_q  <= '0;
            event_q     <= 1'b0;
            lcd_reset_q <= 1'b0;
        end else begin
            wr1_q   <= LT24Wr_n;
            wr2_q   <= wr1_q;
            cs1_q   <= LT24CS_n;
            rs1_q   <= LT24RS;
            rstn1_q <= LT24Reset_n;
            data1_q <= LT24Data;
            // Hold the low-phase bus values so they are stable when the rising edge is seen.
            if (!wr1_q) begin
                cap_cs_n_q <= cs1_q;
                cap_rs_q   <= rs1_q;
                cap_data_q <= data1_q;
            end
            event_q     <= wr1_q & ~wr2_q & ~cap_cs_n_q;
            lcd_reset_q <= ~rstn1_q;
        end
    end

    assign writeEvent = event_q;
    assign isData     = cap_rs_q;
    assign data       = cap_data_q;
    assign lcdReset   = lcd_reset_q;
endmodule

// File: rtl/lt24_bus_decoder.sv
// Decodes ILI9341 CASET/PASET/RAMWR traffic on the LT24 write bus into per-pixel
// (x, y, colour) updates, flagging malformed sequences on protocolError.
module lt24_bus_decoder
    import lt24_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int HEIGHT = LCD_HEIGHT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           LT24Wr_n,
    input  logic           LT24Rd_n,
    input  logic           LT24CS_n,
    input  logic           LT24RS,
    input  logic           LT24Reset_n,
    input  logic           LT24LCDOn,
    input  logic [15:0]    LT24Data,
    output logic           cmdValid,
    output logic [7:0]     cmdCode,
    output logic           pixelValid,
    output logic [X_W-1:0] pixelX,
    output logic [Y_W-1:0] pixelY,
    output logic [15:0]    pixelColour,
    output logic           protocolError
);
    localparam logic [15:0]    X_LIMIT = 16'(WIDTH);
    localparam logic [15:0]    Y_LIMIT = 16'(HEIGHT);
    localparam logic [X_W-1:0] X_LAST  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(HEIGHT - 1);

    logic        write_event, is_data, lcd_reset;
    logic [15:0] bus_data;
    logic        unused_inputs;

    assign unused_inputs = ^{LT24Rd_n, LT24LCDOn};

    lt24_write_strobe u_strobe (
        .clock       (clock),
        .reset       (reset),
        .LT24Wr_n    (LT24Wr_n),
        .LT24CS_n    (LT24CS_n),
        .LT24RS      (LT24RS),
        .LT24Reset_n (LT24Reset_n),
        .LT24Data    (LT24Data),
        .writeEvent  (write_event),
        .isData      (is_data),
        .data        (bus_data),
        .lcdReset    (lcd_reset)
    );

    lt24_state_e    state_q, state_d;
    logic [1:0]     param_cnt_q, param_cnt_d;
    logic [15:0]    start_q, start_d;
    logic [7:0]     end_hi_q, end_hi_d;
    logic [15:0]    end_full;
    logic [X_W-1:0] sc_q, sc_d, ec_q, ec_d, x_q, x_d;
    logic [Y_W-1:0] sp_q, sp_d, ep_q, ep_d, y_q, y_d;
    logic           cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d, error_q, error_d;
    logic [7:0]     cmd_code_q, cmd_code_d;
    logic [X_W-1:0] pix_x_q, pix_x_d;
    logic [Y_W-1:0] pix_y_q, pix_y_d;
    logic [15:0]    pix_colour_q, pix_colour_d;

    always_comb begin
        state_d      = state_q;
        param_cnt_d  = param_cnt_q;
        start_d      = start_q;
        end_hi_d     = end_hi_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        x_d          = x_q;
        y_d          = y_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_colour_d = pix_colour_q;
        error_d      = 1'b0;
        end_full     = {end_hi_q, bus_data[7:0]};

        if (write_event && !is_data) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = bus_data[7:0];
            param_cnt_d = '0;
            case (bus_data[7:0])
                CMD_CASET: state_d = ST_CASET;
                CMD_PASET: state_d = ST_PASET;
                CMD_RAMWR: begin
                    state_d = ST_RAMWR;
                    x_d     = sc_q;
                    y_d     = sp_q;
                end
                default:   state_d = ST_IGNORE;
            endcase
        end else if (write_event) begin
            case (state_q)
                ST_IDLE: error_d = 1'b1;
                ST_CASET, ST_PASET: begin
                    param_cnt_d = param_cnt_q + 2'd1;
                    case (param_cnt_q)
                        2'd0: start_d[15:8] = bus_data[7:0];
                        2'd1: start_d[7:0]  = bus_data[7:0];
                        2'd2: end_hi_d      = bus_data[7:0];
                        default: begin
                            // A rejected window leaves the previous one in force.
                            state_d = ST_IGNORE;
                            if (state_q == ST_CASET) begin
                                if (range_ok(start_q, end_full, X_LIMIT)) begin
                                    sc_d = start_q[X_W-1:0];
                                    ec_d = end_full[X_W-1:0];
                                end else begin
                                    error_d = 1'b1;
                                end
                            end else begin
                                if (range_ok(start_q, end_full, Y_LIMIT)) begin
                                    sp_d = start_q[Y_W-1:0];
                                    ep_d = end_full[Y_W-1:0];
                                end else begin
                                    error_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                ST_RAMWR: begin
                    pix_valid_d  = 1'b1;
                    pix_x_d      = x_q;
                    pix_y_d      = y_q;
                    pix_colour_d = bus_data;
                    if (x_q == ec_q) begin
                        x_d = sc_q;
                        y_d = (y_q == ep_q) ? sp_q : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || lcd_reset) begin
            state_q     <= ST_IDLE;
            param_cnt_q <= '0;
            start_q     <= '0;
            end_hi_q    <= '0;
            sc_q        <= '0;
            ec_q        <= X_LAST;
            sp_q        <= '0;
            ep_q        <= Y_LAST;
            x_q         <= '0;
            y_q         <= '0;
            cmd_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            param_cnt_q <= param_cnt_d;
            start_q     <= start_d;
            end_hi_q    <= end_hi_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_valid_q <= cmd_valid_d;
            pix_valid_q <= pix_valid_d;
            error_q     <= error_d;
        end

        // Held outputs survive a panel reset; only the system reset clears them.
        if (reset) begin
            cmd_code_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_colour_q <= '0;
        end else if (!lcd_reset) begin
            cmd_code_q   <= cmd_code_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_colour_q <= pix_colour_d;
        end
    end

    assign cmdValid      = cmd_valid_q;
    assign cmdCode       = cmd_code_q;
    assign pixelValid    = pix_valid_q;
    assign pixelX        = pix_x_q;
    assign pixelY        = pix_y_q;
    assign pixelColour   = pix_colour_q;
    assign protocolError = error_q;
endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Bench for lt24_bus_decoder: drives LT24 bus writes and compares decoded output against
// a window/pixel-index reference model.
module tb_lt24_bus_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        LT24Wr_n = 1'b1, LT24Rd_n = 1'b1, LT24CS_n = 1'b1, LT24RS = 1'b0;
    logic        LT24Reset_n = 1'b1, LT24LCDOn = 1'b1;
    logic [15:0] LT24Data = '0;
    logic        cmdValid, pixelValid, protocolError;
    logic [7:0]  cmdCode, pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelColour;

    lt24_bus_decoder dut (
        .clock(clock), .reset(reset), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
        .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n),
        .LT24LCDOn(LT24LCDOn), .LT24Data(LT24Data), .cmdValid(cmdValid), .cmdCode(cmdCode),
        .pixelValid(pixelValid), .pixelX(pixelX), .pixelY(pixelY),
        .pixelColour(pixelColour), .protocolError(protocolError)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- monitor (pixel = {x[7:0], y[8:0], colour[15:0]}) ----------------
    logic [32:0] obs_pix_q[$];
    int          obs_pix_t_q[$];
    logic [7:0]  obs_cmd_q[$];
    int          obs_err = 0;

    always @(negedge clock) begin
        if (pixelValid) begin
            obs_pix_q.push_back({pixelX, pixelY, pixelColour});
            obs_pix_t_q.push_back(cyc);
        end
        if (cmdValid) obs_cmd_q.push_back(cmdCode);
        if (protocolError) obs_err = obs_err + 1;
    end

    // ---------------- reference model ----------------
    logic [32:0] exp_pix_q[$];
    int          exp_pix_t_q[$];
    logic [7:0]  exp_cmd_q[$];
    int          exp_err;
    int m_mode;   // 0 idle, 1 column params, 2 page params, 3 pixel stream, 4 ignore
    int m_pcnt, m_sc, m_ec, m_sp, m_ep, m_n;
    int m_p[4];

    task automatic model_reset();
        m_mode = 0; m_pcnt = 0; m_n = 0;
        m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
    endtask

    task automatic model_write(input logic rs, input logic [15:0] d, input logic cs_n, input int stamp);
        int s, e, w, h, x, y;
        if (cs_n) return;
        if (!rs) begin
            exp_cmd_q.push_back(d[7:0]);
            m_pcnt = 0;
            case (d[7:0])
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_mode = 3; m_n = 0; end
                default: m_mode = 4;
            endcase
        end else if (m_mode == 0) begin
            exp_err++;
        end else if (m_mode == 1 || m_mode == 2) begin
            m_p[m_pcnt] = int'(d[7:0]);
            m_pcnt++;
            if (m_pcnt == 4) begin
                s = m_p[0] * 256 + m_p[1];
                e = m_p[2] * 256 + m_p[3];
                if (s <= e && e < ((m_mode == 1) ? 240 : 320)) begin
                    if (m_mode == 1) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else begin
                    exp_err++;
                end
                m_mode = 4;
            end
        end else if (m_mode == 3) begin
            w = m_ec - m_sc + 1;
            h = m_ep - m_sp + 1;
            x = m_sc + (m_n % w);
            y = m_sp + ((m_n / w) % h);
            exp_pix_q.push_back({8'(x), 9'(y), d});
            exp_pix_t_q.push_back(stamp);
            m_n++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One write event = Wr_n low for one cycle then high for one cycle.
    task automatic bus_write(input logic rs, input logic [15:0] d, input logic cs_n);
        @(negedge clock);
        LT24Wr_n = 1'b0; LT24RS = rs; LT24Data = d; LT24CS_n = cs_n;
        @(negedge clock);
        LT24Wr_n = 1'b1;
        model_write(rs, d, cs_n, cyc + 3);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bus_write(1'b0, {8'h00, c}, 1'b0);
    endtask

    task automatic send_data(input logic [15:0] d);
        bus_write(1'b1, d, 1'b0);
    endtask

    task automatic send_params(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] p, input logic [7:0] q);
        send_cmd(c);
        send_data({8'h00, a}); send_data({8'h00, b}); send_data({8'h00, p}); send_data({8'h00, q});
    endtask

    task automatic flush();
        repeat (6) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; LT24Wr_n = 1'b1; LT24CS_n = 1'b1; LT24Reset_n = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        exp_pix_q.delete(); exp_pix_t_q.delete(); exp_cmd_q.delete(); exp_err = 0;
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        tests++; if (cmdValid !== 1'b0) begin fails++; $display("FAIL reset_cmdValid: got %b want 0", cmdValid); end
        tests++; if (cmdCode !== 8'h00) begin fails++; $display("FAIL reset_cmdCode: got %h want 00", cmdCode); end
        tests++; if (pixelValid !== 1'b0) begin fails++; $display("FAIL reset_pixelValid: got %b want 0", pixelValid); end
        tests++; if (pixelX !== 8'd0) begin fails++; $display("FAIL reset_pixelX: got %0d want 0", pixelX); end
        tests++; if (pixelY !== 9'd0) begin fails++; $display("FAIL reset_pixelY: got %0d want 0", pixelY); end
        tests++; if (pixelColour !== 16'h0) begin fails++; $display("FAIL reset_pixelColour: got %h want 0000", pixelColour); end
        tests++; if (protocolError !== 1'b0) begin fails++; $display("FAIL reset_protocolError: got %b want 0", protocolError); end
    endtask

    task automatic test_ramwr_basic();
        int pb, cb, eb;
        logic [32:0] want[3];
        apply_reset();
        pb = obs_pix_q.size(); cb = obs_cmd_q.size(); eb = obs_err;
        send_cmd(8'h2C);
        send_data(16'hF800); send_data(16'h07E0); send_data(16'h001F);
        flush();
        want[0] = {8'd0, 9'd0, 16'hF800};
        want[1] = {8'd1, 9'd0, 16'h07E0};
        want[2] = {8'd2, 9'd0, 16'h001F};
        tests++; if (obs_cmd_q.size() - cb != 1) begin fails++; $display("FAIL basic_cmd_count: got %0d want 1", obs_cmd_q.size() - cb); end
        else begin tests++; if (obs_cmd_q[cb] !== 8'h2C) begin fails++; $display("FAIL basic_cmd_code: got %h want 2c", obs_cmd_q[cb]); end end
        tests++; if (obs_pix_q.size() - pb != 3) begin fails++; $display("FAIL basic_pix_count: got %0d want 3", obs_pix_q.size() - pb); end
        for (int i = 0; i < 3; i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== want[i]) begin fails++; $display("FAIL basic_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], want[i]); end
            end
        end
        tests++; if (obs_err != eb) begin fails++; $display("FAIL basic_errors: got %0d want 0", obs_err - eb); end
    endtask

    task automatic test_window();
        int pb, cb;
        apply_reset();
        pb = obs_pix_q.size(); cb = obs_cmd_q.size();
        send_params(8'h2A, 8'd0, 8'd10, 8'd0, 8'd12);
        send_params(8'h2B, 8'd0, 8'd20, 8'd0, 8'd21);
        send_cmd(8'h2C);
        for (int i = 0; i < 7; i++) send_data(16'($urandom));
        flush();
        tests++; if (obs_cmd_q.size() - cb != 3) begin fails++; $display("FAIL window_cmd_count: got %0d want 3", obs_cmd_q.size() - cb); end
        tests++; if (obs_pix_q.size() - pb != exp_pix_q.size()) begin fails++; $display("FAIL window_pix_count: got %0d want %0d", obs_pix_q.size() - pb, exp_pix_q.size()); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL window_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
            end
        end
        if (pb + 6 < obs_pix_q.size()) begin
            tests++;
            if (obs_pix_q[pb + 6][32:16] !== {8'd10, 9'd20}) begin fails++; $display("FAIL window_wrap: got x=%0d y=%0d want x=10 y=20", obs_pix_q[pb + 6][32:25], obs_pix_q[pb + 6][24:16]); end
        end
    endtask

    task automatic test_bad_caset();
        int pb, eb;
        apply_reset();
        pb = obs_pix_q.size(); eb = obs_err;
        send_cmd(8'h2A);
        send_data(16'h0000); send_data(16'h0000); send_data(16'h0000);
        flush();
        tests++; if (obs_err != eb) begin fails++; $display("FAIL badcaset_early_error: got %0d want 0", obs_err - eb); end
        send_data(16'h00F0);
        flush();
        tests++; if (obs_err - eb != 1) begin fails++; $display("FAIL badcaset_error: got %0d want 1", obs_err - eb); end
        send_cmd(8'h2C);
        for (int i = 0; i < 241; i++) send_data(16'($urandom));
        flush();
        tests++; if (obs_pix_q.size() - pb != 241) begin fails++; $display("FAIL badcaset_pix_count: got %0d want 241", obs_pix_q.size() - pb); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL badcaset_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
            end
        end
        if (pb + 240 < obs_pix_q.size()) begin
            tests++;
            if (obs_pix_q[pb + 239][32:16] !== {8'd239, 9'd0}) begin fails++; $display("FAIL badcaset_last_col: got %h want x=239 y=0", obs_pix_q[pb + 239][32:16]); end
            tests++;
            if (obs_pix_q[pb + 240][32:16] !== {8'd0, 9'd1}) begin fails++; $display("FAIL badcaset_wrap: got %h want x=0 y=1", obs_pix_q[pb + 240][32:16]); end
        end
    endtask

    task automatic test_data_in_idle();
        int pb, eb;
        apply_reset();
        pb = obs_pix_q.size(); eb = obs_err;
        send_data(16'h1234);
        flush();
        tests++; if (obs_err - eb != 1) begin fails++; $display("FAIL idle_data_error: got %0d want 1", obs_err - eb); end
        tests++; if (obs_pix_q.size() != pb) begin fails++; $display("FAIL idle_data_pixel: got %0d want 0", obs_pix_q.size() - pb); end
    endtask

    task automatic test_cs_high();
        int pb, cb, eb;
        apply_reset();
        pb = obs_pix_q.size(); cb = obs_cmd_q.size(); eb = obs_err;
        bus_write(1'b0, 16'h002C, 1'b1);
        bus_write(1'b1, 16'hABCD, 1'b1);
        bus_write(1'b0, 16'h002A, 1'b1);
        flush();
        tests++; if (obs_cmd_q.size() != cb) begin fails++; $display("FAIL cshigh_cmd: got %0d want 0", obs_cmd_q.size() - cb); end
        tests++; if (obs_pix_q.size() != pb) begin fails++; $display("FAIL cshigh_pixel: got %0d want 0", obs_pix_q.size() - pb); end
        tests++; if (obs_err != eb) begin fails++; $display("FAIL cshigh_error: got %0d want 0", obs_err - eb); end
        // Parameters interrupted by deselected writes must resume where they left off.
        send_cmd(8'h2A); send_data(16'h0000); send_data(16'h0005);
        bus_write(1'b1, 16'h00FF, 1'b1);
        bus_write(1'b1, 16'h00FF, 1'b1);
        send_data(16'h0000); send_data(16'h0007);
        send_cmd(8'h2C);
        for (int i = 0; i < 4; i++) send_data(16'($urandom));
        flush();
        tests++; if (obs_pix_q.size() - pb != exp_pix_q.size()) begin fails++; $display("FAIL csresume_pix_count: got %0d want %0d", obs_pix_q.size() - pb, exp_pix_q.size()); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL csresume_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
            end
        end
        if (pb + 3 < obs_pix_q.size()) begin
            tests++;
            if (obs_pix_q[pb + 3][32:16] !== {8'd5, 9'd1}) begin fails++; $display("FAIL csresume_wrap: got %h want x=5 y=1", obs_pix_q[pb + 3][32:16]); end
        end
    endtask

    task automatic test_back_to_back();
        int pb;
        apply_reset();
        send_params(8'h2A, 8'd0, 8'd100, 8'd0, 8'd103);
        send_cmd(8'h2C);
        pb = obs_pix_q.size();
        for (int i = 0; i < 20; i++) send_data(16'($urandom));
        flush();
        tests++; if (obs_pix_q.size() - pb != exp_pix_q.size()) begin fails++; $display("FAIL b2b_pix_count: got %0d want %0d", obs_pix_q.size() - pb, exp_pix_q.size()); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL b2b_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
                tests++;
                if (obs_pix_t_q[pb + i] != exp_pix_t_q[i]) begin fails++; $display("FAIL b2b_latency[%0d]: got cycle %0d want %0d", i, obs_pix_t_q[pb + i], exp_pix_t_q[i]); end
            end
        end
    endtask

    task automatic test_lcd_reset();
        int pb, eb;
        apply_reset();
        pb = obs_pix_q.size();
        send_params(8'h2A, 8'd0, 8'd0, 8'd0, 8'd9);
        send_params(8'h2B, 8'd0, 8'd0, 8'd0, 8'd9);
        send_cmd(8'h2C);
        for (int i = 0; i < 35; i++) send_data(16'($urandom));   // cursor now at (5,3)
        flush();
        @(negedge clock); LT24Reset_n = 1'b0;
        repeat (2) @(negedge clock); LT24Reset_n = 1'b1;
        model_reset();
        flush();
        eb = obs_err;
        send_data(16'h5555);
        flush();
        tests++; if (obs_err - eb != 1) begin fails++; $display("FAIL lcdreset_idle_error: got %0d want 1", obs_err - eb); end
        send_cmd(8'h2C);
        for (int i = 0; i < 242; i++) send_data(16'($urandom));
        flush();
        tests++; if (obs_pix_q.size() - pb != exp_pix_q.size()) begin fails++; $display("FAIL lcdreset_pix_count: got %0d want %0d", obs_pix_q.size() - pb, exp_pix_q.size()); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL lcdreset_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
            end
        end
        if (pb + 35 + 240 < obs_pix_q.size()) begin
            tests++;
            if (obs_pix_q[pb + 35][32:16] !== {8'd0, 9'd0}) begin fails++; $display("FAIL lcdreset_origin: got %h want x=0 y=0", obs_pix_q[pb + 35][32:16]); end
            tests++;
            if (obs_pix_q[pb + 35 + 240][32:16] !== {8'd0, 9'd1}) begin fails++; $display("FAIL lcdreset_default_width: got %h want x=0 y=1", obs_pix_q[pb + 35 + 240][32:16]); end
        end
    endtask

    task automatic test_random();
        int pb, cb, eb, op;
        logic [15:0] d;
        logic cs_n;
        apply_reset();
        pb = obs_pix_q.size(); cb = obs_cmd_q.size(); eb = obs_err;
        for (int i = 0; i < 300; i++) begin
            op   = $urandom_range(0, 99);
            cs_n = ($urandom_range(0, 9) == 0);
            d    = 16'($urandom);
            if (op < 8)       bus_write(1'b0, 16'h002A, cs_n);
            else if (op < 16) bus_write(1'b0, 16'h002B, cs_n);
            else if (op < 24) bus_write(1'b0, 16'h002C, cs_n);
            else if (op < 27) bus_write(1'b0, d, cs_n);
            else begin
                // Keep high parameter bytes mostly zero so most windows are legal.
                if ((m_mode == 1 || m_mode == 2) && (m_pcnt == 0 || m_pcnt == 2))
                    d[7:0] = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
                bus_write(1'b1, d, cs_n);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        flush();
        tests++; if (obs_err - eb != exp_err) begin fails++; $display("FAIL random_errors: got %0d want %0d", obs_err - eb, exp_err); end
        tests++; if (obs_cmd_q.size() - cb != exp_cmd_q.size()) begin fails++; $display("FAIL random_cmd_count: got %0d want %0d", obs_cmd_q.size() - cb, exp_cmd_q.size()); end
        for (int i = 0; i < exp_cmd_q.size(); i++) begin
            if (cb + i < obs_cmd_q.size()) begin
                tests++;
                if (obs_cmd_q[cb + i] !== exp_cmd_q[i]) begin fails++; $display("FAIL random_cmd[%0d]: got %h want %h", i, obs_cmd_q[cb + i], exp_cmd_q[i]); end
            end
        end
        tests++; if (obs_pix_q.size() - pb != exp_pix_q.size()) begin fails++; $display("FAIL random_pix_count: got %0d want %0d", obs_pix_q.size() - pb, exp_pix_q.size()); end
        for (int i = 0; i < exp_pix_q.size(); i++) begin
            if (pb + i < obs_pix_q.size()) begin
                tests++;
                if (obs_pix_q[pb + i] !== exp_pix_q[i]) begin fails++; $display("FAIL random_pixel[%0d]: got %h want %h", i, obs_pix_q[pb + i], exp_pix_q[i]); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramwr_basic();
        test_window();
        test_bad_caset();
        test_data_in_idle();
        test_cs_high();
        test_back_to_back();
        test_lcd_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
